// File: rtl/message_scroller_if.sv
// Message scroller bus: button/auto-scroll controls, message write port and the
// visible character window. The optional dir signal exists only when
// SCROLL_REVERSE_EN is defined.
interface message_scroller_if #(
   parameter int unsigned AW = 4
);
   logic          btn_raw;
   logic          auto_en;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [3:0]    mem_wdata;
`ifdef SCROLL_REVERSE_EN
   logic          dir;
`endif
   logic [AW-1:0] offset;
   logic [3:0]    char3;
   logic [3:0]    char2;
   logic [3:0]    char1;
   logic [3:0]    char0;
   logic          step_pulse;

   modport master (
      output btn_raw, auto_en, mem_we, mem_waddr, mem_wdata,
`ifdef SCROLL_REVERSE_EN
      output dir,
`endif
      input  offset, char3, char2, char1, char0, step_pulse
   );

   modport slave (
      input  btn_raw, auto_en, mem_we, mem_waddr, mem_wdata,
`ifdef SCROLL_REVERSE_EN
      input  dir,
`endif
      output offset, char3, char2, char1, char0, step_pulse
   );
endinterface

// File: rtl/message_scroller.sv
// Message scroller: holds a 2**MSG_DEPTH_LOG2-entry message of 4-bit character
// codes and presents the four characters visible at the current scroll offset.
// The offset advances on a debounced button press or an auto-scroll tick.
// Optional feature macro: SCROLL_REVERSE_EN (adds bus.dir; dir=1 scrolls backwards).
module message_scroller #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned SCROLL_CYCLES   = 5000000,
   parameter int unsigned MSG_DEPTH_LOG2  = 4
) (
   input  logic              clk,
   input  logic              reset,
   message_scroller_if.slave bus
);

   localparam int unsigned Depth = 2 ** MSG_DEPTH_LOG2;
   localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned PsW   = $clog2(SCROLL_CYCLES);

   typedef logic [MSG_DEPTH_LOG2-1:0] off_t;

   logic           sync1_q, sync2_q;
   logic           db_q, db_d, db_prev_q;
   logic [DbW-1:0] db_cnt_q, db_cnt_d;
   logic [PsW-1:0] ps_q, ps_d;
   logic           btn_edge, tick, step;
   off_t           off_q, off_d;
   logic           step_pulse_q;
   logic [3:0]     msg_q  [Depth];
   logic [3:0]     char_q [4];

   // Two-flop synchronizer for the asynchronous button level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= bus.btn_raw;
         sync2_q <= sync1_q;
      end
   end

   // Debounce next state: any agreement with the debounced state restarts the count.
   always_comb begin
      db_d     = db_q;
      db_cnt_d = db_cnt_q;
      if (sync2_q == db_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
         db_d     = ~db_q;
         db_cnt_d = '0;
      end else begin
         db_cnt_d = db_cnt_q + 1'b1;
      end
   end

   // Debounce state, counter and previous state for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         db_q      <= 1'b0;
         db_cnt_q  <= '0;
         db_prev_q <= 1'b0;
      end else begin
         db_q      <= db_d;
         db_cnt_q  <= db_cnt_d;
         db_prev_q <= db_q;
      end
   end

   // Auto-scroll prescaler: held at zero while disabled, wraps on the tick.
   always_comb begin
      tick = bus.auto_en && (ps_q == PsW'(SCROLL_CYCLES - 1));
      ps_d = ps_q + 1'b1;
      if (!bus.auto_en || tick) begin
         ps_d = '0;
      end
   end

   // Prescaler register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ps_q <= '0;
      end else begin
         ps_q <= ps_d;
      end
   end

   // Step decode: a coincident press and tick collapse into one step.
   always_comb begin
      btn_edge = db_q & ~db_prev_q;
      step     = btn_edge | tick;
      off_d    = off_q;
      if (step) begin
`ifdef SCROLL_REVERSE_EN
         off_d = bus.dir ? off_q - 1'b1 : off_q + 1'b1;
`else
         off_d = off_q + 1'b1;
`endif
      end
   end

   // Offset and its one-cycle step indicator, both updated on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         off_q        <= '0;
         step_pulse_q <= 1'b0;
      end else begin
         off_q        <= off_d;
         step_pulse_q <= step;
      end
   end

   // Message storage; reset restores the identity pattern msg[i] = i.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(Depth); i++) begin
            msg_q[i] <= 4'(i);
         end
      end else if (bus.mem_we) begin
         msg_q[bus.mem_waddr] <= bus.mem_wdata;
      end
   end

   // Visible window reloads every cycle, so writes and offset changes show one edge later.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 4; k++) begin
            char_q[k] <= 4'(k);
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            char_q[k] <= msg_q[off_q + off_t'(k)];
         end
      end
   end

   assign bus.offset     = off_q;
   assign bus.step_pulse = step_pulse_q;
   assign bus.char3      = char_q[0];
   assign bus.char2      = char_q[1];
   assign bus.char1      = char_q[2];
   assign bus.char0      = char_q[3];

endmodule

// File: tb/tb_message_scroller.sv
// Bench for message_scroller with DEBOUNCE_CYCLES=4, SCROLL_CYCLES=8.
module tb_message_scroller;

   localparam int unsigned Deb = 4;
   localparam int unsigned Sc  = 8;

   typedef struct {
      logic [3:0]  waddr;
      logic [3:0]  wdata;
      logic [15:0] exp_chars;
   } wr_vec_t;

   logic clk = 1'b0;
   logic reset;

   message_scroller_if #(.AW(4)) sb ();

   message_scroller #(
      .DEBOUNCE_CYCLES (Deb),
      .SCROLL_CYCLES   (Sc),
      .MSG_DEPTH_LOG2  (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sb)
   );

   always #5 clk = ~clk;

   int         n_cmp  = 0;
   int         n_fail = 0;
   logic [3:0] mdl [16];
   int         exp_q [$];
   logic       chk_chars = 1'b0;
   logic [3:0] chk_off;

   task automatic chk(input string nm, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", nm, got, exp);
      end
   endtask

   task automatic mdl_reset();
      for (int i = 0; i < 16; i++) mdl[i] = 4'(i);
   endtask

   function automatic int vis_chars();
      return int'({sb.char3, sb.char2, sb.char1, sb.char0});
   endfunction

   task automatic wait_pulse(input int max, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!sb.step_pulse && n < max);
      if (!sb.step_pulse) begin
         n_cmp++;
         n_fail++;
         $display("FAIL step_timeout: no step_pulse within %0d cycles, required one", max);
         n = -1;
      end
   endtask

   // Scoreboard: every step_pulse pops the predicted offset; the next cycle's
   // characters are checked against the bench's own message model.
   always @(negedge clk) begin
      if (chk_chars) begin
         chk_chars = 1'b0;
         chk("sb_chars", vis_chars(),
             int'({mdl[chk_off], mdl[chk_off + 4'd1], mdl[chk_off + 4'd2], mdl[chk_off + 4'd3]}));
      end
      if (!reset && sb.step_pulse) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb_unexpected_step: offset=%0d, required no step", sb.offset);
         end else begin
            chk("sb_offset", int'(sb.offset), exp_q.pop_front());
         end
         chk_chars = 1'b1;
         chk_off   = sb.offset;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      wr_vec_t vecs [5];
      int n;
      int skip;
      int pulses;

      vecs[0] = '{waddr: 4'd2, wdata: 4'd9,  exp_chars: 16'h0193};
      vecs[1] = '{waddr: 4'd0, wdata: 4'd7,  exp_chars: 16'h7193};
      vecs[2] = '{waddr: 4'd3, wdata: 4'd12, exp_chars: 16'h719C};
      vecs[3] = '{waddr: 4'd1, wdata: 4'd5,  exp_chars: 16'h759C};
      vecs[4] = '{waddr: 4'd6, wdata: 4'd14, exp_chars: 16'h759C};

      reset        = 1'b1;
      sb.btn_raw   = 1'b0;
      sb.auto_en   = 1'b0;
      sb.mem_we    = 1'b0;
      sb.mem_waddr = '0;
      sb.mem_wdata = '0;
`ifdef SCROLL_REVERSE_EN
      sb.dir       = 1'b0;
`endif
      mdl_reset();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // 1. Reset state
      chk("reset_offset", int'(sb.offset), 0);
      chk("reset_step", int'(sb.step_pulse), 0);
      chk("reset_chars", vis_chars(), 16'h0123);

      // 2. Clean press: 2 sync + 4 debounce + 1 register cycles
      sb.btn_raw = 1'b1;
      exp_q.push_back(1);
      wait_pulse(20, n);
      chk("press_latency", n, 7);
      @(negedge clk);
      chk("press_chars", vis_chars(), 16'h1234);
      repeat (3) @(negedge clk);
      sb.btn_raw = 1'b0;
      repeat (15) @(negedge clk);
      chk("release_no_step", int'(sb.offset), 1);

      // 3. Bouncy press: 2-cycle runs never survive debounce
      for (int i = 0; i < 12; i++) begin
         sb.btn_raw = ((i / 2) % 2) == 0;
         @(negedge clk);
      end
      chk("bounce_no_step", int'(sb.offset), 1);
      sb.btn_raw = 1'b1;
      exp_q.push_back(2);
      wait_pulse(20, n);
      chk("bounce_latency", n, 7);
      repeat (8) @(negedge clk);
      sb.btn_raw = 1'b0;
      repeat (15) @(negedge clk);
      chk("bounce_single_step", int'(sb.offset), 2);

      // 4. Auto-scroll: 28 steps from offset 2, wrapping through 15 -> 0
      sb.auto_en = 1'b1;
      for (int k = 0; k < 28; k++) exp_q.push_back((3 + k) % 16);
      skip = 0;
      for (int k = 0; k < 28; k++) begin
         wait_pulse(20, n);
         chk("auto_interval", n, 8 - skip);
         skip = 0;
         if ((3 + k) % 16 == 15) begin
            @(negedge clk);
            chk("wrap_chars_at_15", vis_chars(), 16'hF012);
            skip = 1;
         end
      end
      sb.auto_en = 1'b0;
      chk("auto_final_offset", int'(sb.offset), 14);

      // 5. Debounced press aligned with an auto tick: one step only
      sb.auto_en = 1'b1;
      @(negedge clk);
      sb.btn_raw = 1'b1;
      exp_q.push_back(15);
      pulses = 0;
      repeat (12) begin
         @(negedge clk);
         if (sb.step_pulse) pulses++;
      end
      sb.auto_en = 1'b0;
      chk("coincident_pulses", pulses, 1);
      chk("coincident_offset", int'(sb.offset), 15);
      sb.btn_raw = 1'b0;
      repeat (15) @(negedge clk);

      // Reset back to defaults
      reset = 1'b1;
      #1;
      chk("reset2_offset", int'(sb.offset), 0);
      chk("reset2_chars", vis_chars(), 16'h0123);
      mdl_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Write table at offset 0
      for (int v = 0; v < 5; v++) begin
         sb.mem_we    = 1'b1;
         sb.mem_waddr = vecs[v].waddr;
         sb.mem_wdata = vecs[v].wdata;
         mdl[vecs[v].waddr] = vecs[v].wdata;
         @(negedge clk);
         sb.mem_we = 1'b0;
         @(negedge clk);
         chk($sformatf("write_vec%0d", v), vis_chars(), int'(vecs[v].exp_chars));
      end

      // Write coinciding with an auto tick: both take effect
      sb.auto_en = 1'b1;
      repeat (7) @(negedge clk);
      sb.mem_we    = 1'b1;
      sb.mem_waddr = 4'd1;
      sb.mem_wdata = 4'd10;
      mdl[1] = 4'd10;
      exp_q.push_back(1);
      @(negedge clk);
      sb.mem_we  = 1'b0;
      sb.auto_en = 1'b0;
      chk("write_step_pulse", int'(sb.step_pulse), 1);
      @(negedge clk);
      chk("write_step_chars", vis_chars(), 16'hA9C4);

      // 6. Reset mid-prescale and during a write
      sb.auto_en = 1'b1;
      repeat (4) @(negedge clk);
      sb.mem_we    = 1'b1;
      sb.mem_waddr = 4'd2;
      sb.mem_wdata = 4'd13;
      reset        = 1'b1;
      #1;
      chk("midreset_offset", int'(sb.offset), 0);
      chk("midreset_chars", vis_chars(), 16'h0123);
      chk("midreset_step", int'(sb.step_pulse), 0);
      mdl_reset();
      @(negedge clk);
      sb.mem_we = 1'b0;
      reset     = 1'b0;
      exp_q.push_back(1);
      wait_pulse(20, n);
      chk("post_reset_tick", n, 8);
      sb.auto_en = 1'b0;
      @(negedge clk);
      chk("write_lost_chars", vis_chars(), 16'h1234);

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
